// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32I data-memory responder with fixed-latency load/store responses
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, nextState;
    logic [2:0]      cnt;
    logic            latWe;
    logic [2:0]      latFunct3;
    logic [AW+1:0]   latAddr;
    logic            latErr;
    logic            accept;
    logic            reqMisalign;
    logic [3:0]      byteEn;
    logic [31:0]     byteData;
    logic [31:0]     mem [DEPTH_WORDS];
    logic            srcWe;
    logic [2:0]      srcFunct3;
    logic [AW+1:0]   srcAddr;
    logic            srcErr;
    logic [31:0]     rspNext;
    logic            unusedAddrBits;

    assign accept         = req_valid && req_ready;
    assign unusedAddrBits = ^req_addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign reqMisalign = (((req_funct3 == 3'b001) || (!req_we && req_funct3 == 3'b101)) && req_addr[0])
                       || ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
    assign reqMisalign = 1'b0;
`endif

    function automatic logic [31:0] loadFormat(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 3'd0) nextState = RESP;
            RESP:    if (rsp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && reset;
        busy      = (state != IDLE);
        rsp_valid = (state == RESP);
    end

    // Stores land in memory on the accept edge, so later loads see them regardless of LATENCY.
    always_comb begin
        byteEn   = 4'b0000;
        byteData = 32'd0;
        if (req_we && !reqMisalign) begin
            case (req_funct3)
                3'b000: begin
                    byteEn   = 4'b0001 << req_addr[1:0];
                    byteData = {4{req_wdata[7:0]}};
                end
                3'b001: begin
                    byteEn   = req_addr[1] ? 4'b1100 : 4'b0011;
                    byteData = {2{req_wdata[15:0]}};
                end
                3'b010: begin
                    byteEn   = 4'b1111;
                    byteData = req_wdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[req_addr[AW+1:2]][8*i +: 8] <= byteData[8*i +: 8];
            end
        end
    end

    // With LATENCY=1 RESP is entered on the accept edge, before the latches hold the request.
    always_comb begin
        if (state == IDLE) begin
            srcWe     = req_we;
            srcFunct3 = req_funct3;
            srcAddr   = req_addr[AW+1:0];
            srcErr    = reqMisalign;
        end else begin
            srcWe     = latWe;
            srcFunct3 = latFunct3;
            srcAddr   = latAddr;
            srcErr    = latErr;
        end
        rspNext = (srcWe || srcErr) ? 32'd0
                : loadFormat(srcFunct3, srcAddr[1:0], mem[srcAddr[AW+1:2]]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 3'd0;
            latWe     <= 1'b0;
            latFunct3 <= 3'd0;
            latAddr   <= '0;
            latErr    <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                latWe     <= req_we;
                latFunct3 <= req_funct3;
                latAddr   <= req_addr[AW+1:0];
                latErr    <= reqMisalign;
                cnt       <= CNT_INIT;
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (nextState == RESP && state != RESP) begin
                rsp_rdata <= rspNext;
                rsp_err   <= srcErr;
            end
        end
    end
endmodule
